// File: rtl/care_actions.sv
// care_actions: turns debounced feed/play/sleep presses into one-cycle level-raise pulses,
// with per-action cooldowns, a timed sleep session and rejection of illegal presses.
module care_actions #(
  parameter int unsigned TICK_CYCLES     = 50,
  parameter int unsigned DEB_CYCLES      = 8,
  parameter int unsigned FEED_COOLDOWN_S = 5,
  parameter int unsigned PLAY_COOLDOWN_S = 3,
  parameter int unsigned SLEEP_STEP_S    = 4,
  parameter int unsigned MAX_LEVEL       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_feed,
  input  logic       btn_play,
  input  logic       btn_sleep,
  input  logic [2:0] foodValue,
  input  logic [2:0] sleepValue,
  input  logic [2:0] funValue,
  input  logic [2:0] happyValue,
  output logic       upFood,
  output logic       upSleep,
  output logic       upFun,
  output logic       upHappy,
  output logic       reject,
  output logic       busy,
  output logic       sleeping
);

  localparam int unsigned DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PRE_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned CD_MAX  = (FEED_COOLDOWN_S > PLAY_COOLDOWN_S) ? FEED_COOLDOWN_S
                                                                        : PLAY_COOLDOWN_S;
  localparam int unsigned SEC_MAX = (CD_MAX > SLEEP_STEP_S) ? CD_MAX : SLEEP_STEP_S;
  localparam int unsigned SEC_W   = $clog2(SEC_MAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FEEDING  = 3'd1;
  localparam logic [2:0] S_PLAYING  = 3'd2;
  localparam logic [2:0] S_SLEEPING = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;

  localparam logic [2:0] LVL_MAX = 3'(MAX_LEVEL);

  // Button vectors are ordered {sleep, play, feed}
  logic [2:0]            btn_raw;
  logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]            deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [2:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]            ev_c;

  logic [2:0]       state_q, state_d;
  logic [SEC_W-1:0] limit_q, limit_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             tick_c, step_c, run_c;

  logic up_food_q, up_food_d, up_fun_q, up_fun_d, up_happy_q, up_happy_d;
  logic up_sleep_q, up_sleep_d, reject_q, reject_d, busy_q, busy_d;
  logic sleeping_q, sleeping_d;

  assign btn_raw = {btn_sleep, btn_play, btn_feed};

  // Synchronize, debounce and detect rising edges of the debounced levels
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    deb_cnt_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end
    ev_c = deb_q & ~deb_prev_q;
  end

  assign tick_c = (presc_q == PRE_W'(TICK_CYCLES - 1));
  assign step_c = tick_c && (sec_q == SEC_W'(SLEEP_STEP_S - 1));

  // Next-state, pulse decisions and second timebase
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    up_food_d  = 1'b0;
    up_fun_d   = 1'b0;
    up_happy_d = 1'b0;
    up_sleep_d = 1'b0;
    reject_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_c[2]) begin
          if (sleepValue < LVL_MAX) state_d = S_SLEEPING;
          else reject_d = 1'b1;
        end else if (ev_c[0]) begin
          if (foodValue < LVL_MAX) begin
            state_d   = S_FEEDING;
            up_food_d = 1'b1;
          end else reject_d = 1'b1;
        end else if (ev_c[1]) begin
          if (funValue < LVL_MAX) begin
            state_d    = S_PLAYING;
            up_fun_d   = 1'b1;
            up_happy_d = (foodValue >= 3'd3) && (happyValue < LVL_MAX);
          end else reject_d = 1'b1;
        end
      end
      S_FEEDING: begin
        state_d  = S_COOLDOWN;
        limit_d  = SEC_W'(FEED_COOLDOWN_S);
        reject_d = |ev_c;
      end
      S_PLAYING: begin
        state_d  = S_COOLDOWN;
        limit_d  = SEC_W'(PLAY_COOLDOWN_S);
        reject_d = |ev_c;
      end
      S_COOLDOWN: begin
        reject_d = |ev_c;
        if (sec_q == limit_q) state_d = S_IDLE;
      end
      S_SLEEPING: begin
        if (ev_c[2]) begin
          state_d = S_IDLE;
        end else begin
          reject_d = ev_c[0] | ev_c[1];
          // A level already at max only ends the session once our own pulse has landed
          if ((sleepValue == LVL_MAX) && !up_sleep_q) state_d = S_IDLE;
          else if (step_c && (sleepValue < LVL_MAX)) up_sleep_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timebase runs only while staying in a timed state, so entry always starts from zero
    run_c   = ((state_q == S_COOLDOWN) || (state_q == S_SLEEPING)) && (state_d == state_q);
    presc_d = '0;
    sec_d   = '0;
    if (run_c) begin
      presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
      if (state_q == S_SLEEPING) sec_d = step_c ? '0 : (tick_c ? sec_q + SEC_W'(1) : sec_q);
      else sec_d = tick_c ? sec_q + SEC_W'(1) : sec_q;
    end

    busy_d     = (state_d != S_IDLE);
    sleeping_d = (state_d == S_SLEEPING);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      deb_cnt_q  <= '0;
      state_q    <= S_IDLE;
      limit_q    <= '0;
      presc_q    <= '0;
      sec_q      <= '0;
      up_food_q  <= 1'b0;
      up_fun_q   <= 1'b0;
      up_happy_q <= 1'b0;
      up_sleep_q <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
      sleeping_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      limit_q    <= limit_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      up_food_q  <= up_food_d;
      up_fun_q   <= up_fun_d;
      up_happy_q <= up_happy_d;
      up_sleep_q <= up_sleep_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
      sleeping_q <= sleeping_d;
    end
  end

  assign upFood   = up_food_q;
  assign upFun    = up_fun_q;
  assign upHappy  = up_happy_q;
  assign upSleep  = up_sleep_q;
  assign reject   = reject_q;
  assign busy     = busy_q;
  assign sleeping = sleeping_q;

endmodule

// File: tb/tb_care_actions.sv
// Directed bench for care_actions: vector table for single presses plus multi-cycle sequences.
module tb_care_actions;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_feed = 1'b0, btn_play = 1'b0, btn_sleep = 1'b0;
  logic [2:0] foodValue = 3'd0, sleepValue = 3'd0, funValue = 3'd0, happyValue = 3'd0;
  logic       upFood, upSleep, upFun, upHappy, reject, busy, sleeping;

  int n_pass = 0;
  int n_total = 0;

  care_actions #(
    .TICK_CYCLES(10), .DEB_CYCLES(4), .FEED_COOLDOWN_S(2),
    .PLAY_COOLDOWN_S(1), .SLEEP_STEP_S(2), .MAX_LEVEL(5)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_feed(btn_feed), .btn_play(btn_play), .btn_sleep(btn_sleep),
    .foodValue(foodValue), .sleepValue(sleepValue), .funValue(funValue),
    .happyValue(happyValue),
    .upFood(upFood), .upSleep(upSleep), .upFun(upFun), .upHappy(upHappy),
    .reject(reject), .busy(busy), .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  logic [6:0] obs;
  assign obs = {upFood, upFun, upHappy, upSleep, reject, busy, sleeping};

  typedef struct {
    logic [2:0] btn;   // {sleep, play, feed}
    logic [2:0] food;
    logic [2:0] fun;
    logic [2:0] slp;
    logic [2:0] happy;
    logic [6:0] exp;   // {upFood, upFun, upHappy, upSleep, reject, busy, sleeping}
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_feed = 1'b0; btn_play = 1'b0; btn_sleep = 1'b0;
    foodValue = 3'd0; funValue = 3'd0; sleepValue = 3'd0; happyValue = 3'd0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  initial begin
    int cnt_food, first_food, cnt_busy, last_busy, cnt_rej, rej_at;
    int cnt_slp, slp1, slp2, last_slp_hi, pend;

    vecs[0]  = '{3'b001, 3'd2, 3'd0, 3'd0, 3'd0, 7'b1000010};
    vecs[1]  = '{3'b001, 3'd5, 3'd0, 3'd0, 3'd0, 7'b0000100};
    vecs[2]  = '{3'b010, 3'd4, 3'd0, 3'd0, 3'd2, 7'b0110010};
    vecs[3]  = '{3'b010, 3'd2, 3'd0, 3'd0, 3'd2, 7'b0100010};
    vecs[4]  = '{3'b010, 3'd4, 3'd5, 3'd0, 3'd2, 7'b0000100};
    vecs[5]  = '{3'b010, 3'd3, 3'd0, 3'd0, 3'd4, 7'b0110010};
    vecs[6]  = '{3'b010, 3'd3, 3'd0, 3'd0, 3'd5, 7'b0100010};
    vecs[7]  = '{3'b100, 3'd0, 3'd0, 3'd1, 3'd0, 7'b0000011};
    vecs[8]  = '{3'b100, 3'd0, 3'd0, 3'd5, 3'd0, 7'b0000100};
    vecs[9]  = '{3'b101, 3'd0, 3'd0, 3'd1, 3'd0, 7'b0000011};
    vecs[10] = '{3'b011, 3'd1, 3'd0, 3'd0, 3'd0, 7'b1000010};
    vecs[11] = '{3'b110, 3'd0, 3'd0, 3'd5, 3'd0, 7'b0000100};
    vecs[12] = '{3'b001, 3'd4, 3'd0, 3'd0, 3'd0, 7'b1000010};
    vecs[13] = '{3'b011, 3'd5, 3'd0, 3'd0, 3'd0, 7'b0000100};

    // Reset state
    repeat (2) step();
    check("reset_outputs", int'(obs), 0);

    // Single press vectors: quiet one cycle before the response, response 7 cycles after rise
    for (int v = 0; v < 14; v++) begin
      do_reset();
      foodValue = vecs[v].food; funValue = vecs[v].fun;
      sleepValue = vecs[v].slp; happyValue = vecs[v].happy;
      {btn_sleep, btn_play, btn_feed} = vecs[v].btn;
      repeat (6) step();
      check($sformatf("vec%0d_quiet", v), int'(obs), 0);
      step();
      check($sformatf("vec%0d_resp", v), int'(obs), int'(vecs[v].exp));
    end

    // Feed with cooldown and a second press rejected during cooldown
    do_reset();
    foodValue = 3'd2;
    btn_feed = 1'b1;
    cnt_food = 0; first_food = -1; cnt_busy = 0; last_busy = -1; cnt_rej = 0; rej_at = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 8)  btn_feed = 1'b0;
      if (c == 15) btn_feed = 1'b1;
      if (c == 30) btn_feed = 1'b0;
      if (upFood) begin cnt_food++; if (first_food < 0) first_food = c; end
      if (busy) begin cnt_busy++; last_busy = c; end
      if (reject) begin cnt_rej++; rej_at = c; end
    end
    check("feed_count", cnt_food, 1);
    check("feed_latency", first_food, 7);
    check("feed_busy_cycles", cnt_busy, 22);
    check("feed_busy_last", last_busy, 28);
    check("cooldown_reject_count", cnt_rej, 1);
    check("cooldown_reject_cycle", rej_at, 22);

    // Bouncing feed button, then held
    do_reset();
    foodValue = 3'd2;
    cnt_food = 0;
    for (int c = 0; c < 80; c++) begin
      if (c < 20) btn_feed = ((c / 2) % 2 == 0);
      else btn_feed = 1'b1;
      step();
      if (upFood) cnt_food++;
    end
    check("bounce_feed_count", cnt_food, 1);

    // Sleep session with the bench raising sleepValue on each upSleep
    do_reset();
    sleepValue = 3'd3;
    btn_sleep = 1'b1;
    cnt_slp = 0; slp1 = -1; slp2 = -1; last_slp_hi = -1; pend = 0; cnt_rej = 0;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (pend != 0) begin sleepValue = sleepValue + 3'd1; pend = 0; end
      if (c == 8) btn_sleep = 1'b0;
      if (upSleep) begin
        cnt_slp++;
        if (slp1 < 0) slp1 = c; else slp2 = c;
        pend = 1;
      end
      if (sleeping) last_slp_hi = c;
      if (reject) cnt_rej++;
    end
    check("sleep_up_count", cnt_slp, 2);
    check("sleep_up_first", slp1, 27);
    check("sleep_up_second", slp2, 47);
    check("sleep_last_high", last_slp_hi, 48);
    check("sleep_after_exit", int'({sleeping, busy}), 0);
    check("sleep_no_reject", cnt_rej, 0);

    // Feed press during sleep is rejected, then a sleep press wakes immediately
    do_reset();
    sleepValue = 3'd1;
    btn_sleep = 1'b1;
    cnt_slp = 0; slp1 = -1; last_slp_hi = -1; cnt_rej = 0; rej_at = -1; cnt_food = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 8)  btn_sleep = 1'b0;
      if (c == 10) btn_feed = 1'b1;
      if (c == 20) btn_feed = 1'b0;
      if (c == 30) btn_sleep = 1'b1;
      if (c == 45) btn_sleep = 1'b0;
      if (upSleep) begin cnt_slp++; if (slp1 < 0) slp1 = c; end
      if (sleeping) last_slp_hi = c;
      if (reject) begin cnt_rej++; rej_at = c; end
      if (upFood) cnt_food++;
    end
    check("sleep_feed_reject_cycle", rej_at, 17);
    check("sleep_feed_reject_count", cnt_rej, 1);
    check("sleep_feed_no_upfood", cnt_food, 0);
    check("sleep_continues_up", slp1, 27);
    check("wake_no_more_up", cnt_slp, 1);
    check("wake_last_sleeping", last_slp_hi, 36);

    // Reset in the middle of cooldown, then a fresh feed is accepted
    do_reset();
    foodValue = 3'd2;
    btn_feed = 1'b1;
    cnt_food = 0; first_food = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 8) btn_feed = 1'b0;
      if (c == 12) begin
        check("mid_cooldown_busy", int'(busy), 1);
        rst = 1'b0;
      end
      if (c == 13) check("reset_mid_cooldown_outputs", int'(obs), 0);
      if (c == 14) begin rst = 1'b1; btn_feed = 1'b1; end
      if (c == 15) check("idle_after_reset", int'(busy), 0);
      if (c == 25) btn_feed = 1'b0;
      if (c >= 15 && upFood) begin cnt_food++; if (first_food < 0) first_food = c; end
    end
    check("post_reset_feed_count", cnt_food, 1);
    check("post_reset_feed_cycle", first_food, 21);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/care_actions.md
# care_actions

Player-interaction controller for the pet state machine. It converts raw push-buttons (feed, play, sleep) into single-cycle *up* pulses for the food, fun, sleep and happy level registers. This is the raising side of the same level registers that the time-driven decay FSM lowers. It debounces inputs, enforces per-action cooldowns, runs a timed sleep session, and rejects actions that are illegal in the current state.

## Interface
- `TICK_CYCLES`, 50, clock cycles per game second (matches decay FSM prescale)
- `DEB_CYCLES`, 8, cycles a synchronized button must be stable before its level is accepted
- `FEED_COOLDOWN_S`, 5, seconds locked out after a feed
- `PLAY_COOLDOWN_S`, 3, seconds locked out after a play
- `SLEEP_STEP_S`, 4, seconds between sleep increments
- `MAX_LEVEL`, 5, saturation level of all 3-bit level registers
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-low; clock clk
- `btn_feed`, `btn_play`, `btn_sleep` in 1 each: raw asynchronous buttons, active-high
- `foodValue`, `sleepValue`, `funValue`, `happyValue` in 3 each: current register levels
- `upFood`, `upSleep`, `upFun`, `upHappy` out 1 each: one-cycle increment requests
- `reject` out 1: one-cycle pulse when a press event is discarded
- `busy` out 1: high whenever the state is not IDLE
- `sleeping` out 1: high in SLEEPING

## Operation
- Per button:
  - 2-flop synchronizer.
  - Debounce counter: the debounced level takes the synchronized value after DEB_CYCLES consecutive equal samples.
  - A press event is a 0→1 transition of the debounced level, lasting one cycle. Releases generate nothing.
- Simultaneous events: priority is sleep > feed > play. Lower-priority simultaneous events are dropped silently, with no reject.
- FSM states: IDLE, FEEDING, PLAYING, SLEEPING, COOLDOWN.
- IDLE:
  - Sleep event: if sleepValue < MAX_LEVEL go to SLEEPING, else reject.
  - Feed event: if foodValue < MAX_LEVEL go to FEEDING, else reject.
  - Play event: if funValue < MAX_LEVEL go to PLAYING, else reject.
- FEEDING (1 cycle): upFood=1, then COOLDOWN with limit FEED_COOLDOWN_S.
- PLAYING (1 cycle): upFun=1. In the same cycle, upHappy=1 iff foodValue ≥ 3 and happyValue < MAX_LEVEL. Then COOLDOWN with limit PLAY_COOLDOWN_S.
- COOLDOWN:
  - Counts game seconds. Goes to IDLE in the cycle after the second count reaches the limit.
  - Every press event here produces reject.
- SLEEPING:
  - Counts seconds. When the count reaches SLEEP_STEP_S: if sleepValue < MAX_LEVEL, upSleep=1 for one cycle; the count then clears.
  - Exits to IDLE, with no cooldown, when sleepValue == MAX_LEVEL in any cycle where upSleep is not being driven, or on a sleep press event (wake).
  - Feed and play events produce reject.
- Second timebase:
  - Prescaler 0..TICK_CYCLES-1. It is cleared on entry to COOLDOWN or SLEEPING, so the first tick comes exactly TICK_CYCLES cycles after entry.
  - The second counter is also cleared on entry.
- Counter widths use $clog2 of the relevant maximum. No counter wraps inside its range.
- Outputs are registered. The up*/reject pulses are never longer than one cycle. At most one of upFood/upFun/upSleep is high per cycle.

## Timing
- Reset (rst=0 at a clk edge):
  - All outputs 0.
  - State IDLE.
  - Synchronizers, debounced levels, debounce, prescaler and second counters all 0.
- Reset mid-sleep or mid-cooldown aborts with no pulse.
- A button held through reset release yields one press event once debounce completes.
- Press latency: a raw rise stable from cycle 0 gives a debounced level high at cycle 2+DEB_CYCLES. The event is detected that cycle, and the state/up pulse is registered one cycle later.
- FEEDING → COOLDOWN is 1 cycle. COOLDOWN occupies exactly limit×TICK_CYCLES+1 cycles, and IDLE accepts events on the following cycle.
- Sleep increments are spaced exactly SLEEP_STEP_S×TICK_CYCLES cycles. The first increment comes SLEEP_STEP_S×TICK_CYCLES cycles after entry.
- A reject pulse is asserted the cycle after the discarded event.
- Level inputs are sampled combinationally in the decision cycle. A register update caused by the block's own pulse is visible one cycle later.

## Test plan
Parameters for all tests: TICK_CYCLES=10, DEB_CYCLES=4, FEED_COOLDOWN_S=2, PLAY_COOLDOWN_S=1, SLEEP_STEP_S=2, MAX_LEVEL=5.
- Feed with foodValue=2:
  - One upFood pulse, 7 cycles after the raw rise.
  - busy high for 1+21 cycles.
  - A second feed press during cooldown gives a reject and no upFood.
- Bounce: btn_feed toggled every 2 cycles for 20 cycles, then held → exactly one upFood.
- Play with foodValue=4, happyValue=2 → upFun and upHappy in the same cycle. With foodValue=2 → upFun only. With funValue=5 → reject only.
- Sleep with sleepValue=3, with the bench incrementing sleepValue on each upSleep:
  - upSleep at +20 and +40 cycles after entry.
  - Exit to IDLE when the level reaches 5.
  - sleeping low afterwards.
- Sleep session interruptions:
  - Feed press during a sleep session → reject, and the sleep continues.
  - Sleep press → immediate exit, no upSleep.
- Simultaneous feed and sleep events with sleepValue=1 → SLEEPING, no upFood, no reject.
- rst=0 asserted mid-cooldown → all outputs 0 at the next edge. IDLE after release, and a new feed is accepted.
